// File: rtl/ps2_pkg.sv
// Shared scancode constants, prefix FSM states and direction encoding for the
// PS/2 direction decoder.
package ps2_pkg;

  localparam logic [7:0] ScExt     = 8'hE0;
  localparam logic [7:0] ScBrk     = 8'hF0;

  localparam logic [7:0] ScP0Up    = 8'h1D;
  localparam logic [7:0] ScP0Left  = 8'h1C;
  localparam logic [7:0] ScP0Down  = 8'h1B;
  localparam logic [7:0] ScP0Right = 8'h23;

  localparam logic [7:0] ScP1Up    = 8'h75;
  localparam logic [7:0] ScP1Left  = 8'h6B;
  localparam logic [7:0] ScP1Down  = 8'h72;
  localparam logic [7:0] ScP1Right = 8'h74;

  typedef enum logic [1:0] {
    StIdle,
    StExt,
    StBrk,
    StExtBrk
  } ps2_state_e;

  typedef enum logic [1:0] {
    DirUp    = 2'd0,
    DirRight = 2'd1,
    DirDown  = 2'd2,
    DirLeft  = 2'd3
  } dir_e;

  typedef struct packed {
    logic hit;
    dir_e dir;
  } key_map_t;

  function automatic key_map_t map_p0(input logic [7:0] code);
    key_map_t m;
    m.hit = 1'b1;
    m.dir = DirUp;
    case (code)
      ScP0Up:    m.dir = DirUp;
      ScP0Right: m.dir = DirRight;
      ScP0Down:  m.dir = DirDown;
      ScP0Left:  m.dir = DirLeft;
      default:   m.hit = 1'b0;
    endcase
    return m;
  endfunction

  function automatic key_map_t map_p1(input logic [7:0] code);
    key_map_t m;
    m.hit = 1'b1;
    m.dir = DirUp;
    case (code)
      ScP1Up:    m.dir = DirUp;
      ScP1Right: m.dir = DirRight;
      ScP1Down:  m.dir = DirDown;
      ScP1Left:  m.dir = DirLeft;
      default:   m.hit = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/player_dir_arbiter.sv
// Per-player held-key tracking: last pressed direction wins, and releasing the
// current key falls back to a remaining held key (up > right > down > left).
module player_dir_arbiter
  import ps2_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       make_i,
  input  logic       brk_i,
  input  dir_e       dir_i,
  input  logic       clear_i,
  output logic [3:0] onehot_o
);

  logic [3:0] held_q, held_d;
  dir_e       cur_q, cur_d;
  logic       valid_q, valid_d;

  always_comb begin
    held_d  = held_q;
    cur_d   = cur_q;
    valid_d = valid_q;
    if (clear_i) begin
      held_d  = '0;
      valid_d = 1'b0;
    end else if (make_i) begin
      // A typematic repeat of an already-held key must not steal focus.
      if (!held_q[dir_i]) begin
        held_d[dir_i] = 1'b1;
        cur_d         = dir_i;
        valid_d       = 1'b1;
      end
    end else if (brk_i && held_q[dir_i]) begin
      held_d[dir_i] = 1'b0;
      if (valid_q && (cur_q == dir_i)) begin
        valid_d = |held_d;
        if (held_d[0]) begin
          cur_d = DirUp;
        end else if (held_d[1]) begin
          cur_d = DirRight;
        end else if (held_d[2]) begin
          cur_d = DirDown;
        end else if (held_d[3]) begin
          cur_d = DirLeft;
        end
      end
    end
  end

  always_comb begin
    onehot_o = '0;
    if (valid_q) begin
      onehot_o[cur_q] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      held_q  <= '0;
      cur_q   <= DirUp;
      valid_q <= 1'b0;
    end else begin
      held_q  <= held_d;
      cur_q   <= cur_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/ps2_dir_decoder.sv
// PS/2 scancode to two-player direction levels (WASD-style and arrow keys).
// Define KEY_TIMEOUT_EN to clear held keys after TIMEOUT_CYCLES without a byte.
module ps2_dir_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 32'd50000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_key_pressed,
  input  logic [7:0] ps2_out,
  output logic       upSig,
  output logic       rightSig,
  output logic       downSig,
  output logic       leftSig,
  output logic       upSig2,
  output logic       rightSig2,
  output logic       downSig2,
  output logic       leftSig2
);

  logic       key_q;
  logic       accept;
  ps2_state_e state_q, state_d;
  key_map_t   map0, map1;
  logic       make0, brk0, make1, brk1;
  logic       clear;
  logic [3:0] p0_dir, p1_dir;

  assign accept = ps2_key_pressed & ~key_q;
  assign map0   = map_p0(ps2_out);
  assign map1   = map_p1(ps2_out);

  always_comb begin
    state_d = state_q;
    make0   = 1'b0;
    brk0    = 1'b0;
    make1   = 1'b0;
    brk1    = 1'b0;
    if (clear) begin
      state_d = StIdle;
    end else if (accept) begin
      case (state_q)
        StIdle: begin
          if (ps2_out == ScExt) begin
            state_d = StExt;
          end else if (ps2_out == ScBrk) begin
            state_d = StBrk;
          end else begin
            make0 = map0.hit;
          end
        end
        StExt: begin
          if (ps2_out == ScBrk) begin
            state_d = StExtBrk;
          end else begin
            state_d = StIdle;
            make1   = map1.hit;
          end
        end
        StBrk: begin
          state_d = StIdle;
          brk0    = map0.hit;
        end
        StExtBrk: begin
          state_d = StIdle;
          brk1    = map1.hit;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      key_q   <= 1'b0;
      state_q <= StIdle;
    end else begin
      key_q   <= ps2_key_pressed;
      state_q <= state_d;
    end
  end

`ifdef KEY_TIMEOUT_EN
  logic [31:0] idle_q, idle_d;

  // Clear fires once, on the edge the counter lands on the limit; it then holds.
  always_comb begin
    idle_d = idle_q;
    clear  = 1'b0;
    if (accept) begin
      idle_d = '0;
    end else if (idle_q != TIMEOUT_CYCLES) begin
      idle_d = idle_q + 32'd1;
      clear  = (idle_d == TIMEOUT_CYCLES);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign clear          = 1'b0;
`endif

  player_dir_arbiter u_p0 (
    .clk_i    (clock),
    .rst_ni   (reset),
    .make_i   (make0),
    .brk_i    (brk0),
    .dir_i    (map0.dir),
    .clear_i  (clear),
    .onehot_o (p0_dir)
  );

  player_dir_arbiter u_p1 (
    .clk_i    (clock),
    .rst_ni   (reset),
    .make_i   (make1),
    .brk_i    (brk1),
    .dir_i    (map1.dir),
    .clear_i  (clear),
    .onehot_o (p1_dir)
  );

  assign upSig     = p0_dir[0];
  assign rightSig  = p0_dir[1];
  assign downSig   = p0_dir[2];
  assign leftSig   = p0_dir[3];
  assign upSig2    = p1_dir[0];
  assign rightSig2 = p1_dir[1];
  assign downSig2  = p1_dir[2];
  assign leftSig2  = p1_dir[3];

endmodule
